// File: rtl/wb_commit_arbiter.sv
// Round-robin writeback arbiter: acks one unit result per cycle, maps its id to a destination
// register through the issue-time id table, and drives a registered regfile write port.
// Optional macro WB_ERROR_CHECK_EN enables the sticky wb_error protocol check.
module wb_commit_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int XLEN      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [ID_W-1:0]           issue_id,
  input  logic [4:0]                issue_rd_addr,
  input  logic [NUM_UNITS-1:0]      unit_done,
  input  logic [NUM_UNITS*ID_W-1:0] unit_id,
  input  logic [NUM_UNITS*XLEN-1:0] unit_rd,
  output logic [NUM_UNITS-1:0]      unit_ack,
  input  logic                      rf_stall,
  output logic                      rf_we,
  output logic [4:0]                rf_addr,
  output logic [XLEN-1:0]           rf_data,
  output logic [ID_W-1:0]           rf_id,
  output logic                      retire_valid,
  output logic                      wb_error
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int DEPTH = 2 ** ID_W;

  logic [PTR_W-1:0]  rr_ptr_r;
  logic [DEPTH-1:0]  tbl_valid_r;
  logic [4:0]        tbl_rd_r [DEPTH];

  logic              rf_we_r;
  logic [4:0]        rf_addr_r;
  logic [XLEN-1:0]   rf_data_r;
  logic [ID_W-1:0]   rf_id_r;
  logic              retire_valid_r;

  logic              grant_s;
  logic [PTR_W-1:0]  winner_s;
  logic [PTR_W-1:0]  next_ptr_s;
  logic [ID_W-1:0]   sel_id_s;
  logic [XLEN-1:0]   sel_data_s;
  logic [NUM_UNITS-1:0] ack_s;
  logic [PTR_W:0]    idx_s;

  // Round-robin scan starting at rr_ptr; nothing is granted during reset or stall
  always_comb begin
    grant_s    = 1'b0;
    winner_s   = '0;
    sel_id_s   = '0;
    sel_data_s = '0;
    ack_s      = '0;
    idx_s      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idx_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
      if (idx_s >= (PTR_W+1)'(NUM_UNITS)) begin
        idx_s = idx_s - (PTR_W+1)'(NUM_UNITS);
      end else begin
        idx_s = idx_s;
      end
      if (!grant_s && rst && !rf_stall && unit_done[idx_s[PTR_W-1:0]]) begin
        grant_s    = 1'b1;
        winner_s   = idx_s[PTR_W-1:0];
        sel_id_s   = unit_id[idx_s[PTR_W-1:0]*ID_W +: ID_W];
        sel_data_s = unit_rd[idx_s[PTR_W-1:0]*XLEN +: XLEN];
        ack_s[idx_s[PTR_W-1:0]] = 1'b1;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Pointer advances past the winner, wrapping at NUM_UNITS
  always_comb begin
    if (winner_s == PTR_W'(NUM_UNITS - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = winner_s + PTR_W'(1);
    end
  end

  assign unit_ack = ack_s;

  // Arbiter pointer, id table and registered commit port
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_r       <= '0;
      tbl_valid_r    <= '0;
      for (int e = 0; e < DEPTH; e++) tbl_rd_r[e] <= 5'd0;
      rf_we_r        <= 1'b0;
      rf_addr_r      <= 5'd0;
      rf_data_r      <= '0;
      rf_id_r        <= '0;
      retire_valid_r <= 1'b0;
    end else begin
      if (grant_s) begin
        rr_ptr_r              <= next_ptr_s;
        retire_valid_r        <= 1'b1;
        rf_id_r               <= sel_id_s;
        rf_data_r             <= sel_data_s;
        rf_addr_r             <= tbl_rd_r[sel_id_s];
        rf_we_r               <= (tbl_rd_r[sel_id_s] != 5'd0);
        tbl_valid_r[sel_id_s] <= 1'b0;
      end else begin
        retire_valid_r <= 1'b0;
        rf_we_r        <= 1'b0;
      end
      // Placed after the retire clear so a same-cycle reissue of that id stays valid
      if (issue_valid) begin
        tbl_valid_r[issue_id] <= 1'b1;
        tbl_rd_r[issue_id]    <= issue_rd_addr;
      end else begin
        tbl_valid_r[issue_id] <= tbl_valid_r[issue_id];
      end
    end
  end

  assign rf_we        = rf_we_r;
  assign rf_addr      = rf_addr_r;
  assign rf_data      = rf_data_r;
  assign rf_id        = rf_id_r;
  assign retire_valid = retire_valid_r;

`ifdef WB_ERROR_CHECK_EN
  logic wb_error_r;
  logic err_s;

  // Retire of an unissued id, or reissue of a live id that is not retiring now
  always_comb begin
    err_s = 1'b0;
    if (grant_s && !tbl_valid_r[sel_id_s]) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
    if (issue_valid && tbl_valid_r[issue_id] && !(grant_s && (sel_id_s == issue_id))) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_error_r <= 1'b0;
    end else begin
      wb_error_r <= wb_error_r | err_s;
    end
  end

  assign wb_error = wb_error_r;
`else
  assign wb_error = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Directed-vector bench for wb_commit_arbiter with hand-computed expectations.
module tb_wb_commit_arbiter;

  localparam int NU = 4;
  localparam int IW = 3;
  localparam int XL = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [IW-1:0]     issue_id;
  logic [4:0]        issue_rd_addr;
  logic [NU-1:0]     unit_done;
  logic [NU*IW-1:0]  unit_id;
  logic [NU*XL-1:0]  unit_rd;
  logic [NU-1:0]     unit_ack;
  logic              rf_stall;
  logic              rf_we;
  logic [4:0]        rf_addr;
  logic [XL-1:0]     rf_data;
  logic [IW-1:0]     rf_id;
  logic              retire_valid;
  logic              wb_error;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_commit_arbiter #(.NUM_UNITS(NU), .ID_W(IW), .XLEN(XL)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_id(issue_id), .issue_rd_addr(issue_rd_addr),
    .unit_done(unit_done), .unit_id(unit_id), .unit_rd(unit_rd), .unit_ack(unit_ack),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_id(rf_id), .retire_valid(retire_valid), .wb_error(wb_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input int rd);
    issue_valid   = 1'b1;
    issue_id      = IW'(id);
    issue_rd_addr = 5'(rd);
    step();
    issue_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_id = '0; issue_rd_addr = 5'd0;
    unit_done = 4'hF; unit_id = '0; unit_rd = '0; rf_stall = 1'b0;

    // reset with all units pending
    step(); step();
    chk("rst_ack", 64'(unit_ack), 64'h0);
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_rv", 64'(retire_valid), 64'h0);
    chk("rst_err", 64'(wb_error), 64'h0);
    chk("rst_addr", 64'(rf_addr), 64'h0);
    unit_done = 4'h0;
    rst = 1'b1;
    step();

    // single retirement: id 2 -> x5 from unit 0
    issue(2, 5);
    unit_done = 4'b0001; unit_id[0*IW +: IW] = 3'd2; unit_rd[0*XL +: XL] = 32'h8000_0000;
    #1 chk("single_ack", 64'(unit_ack), 64'h1);
    step();
    unit_done = 4'h0;
    chk("single_we", 64'(rf_we), 64'h1);
    chk("single_addr", 64'(rf_addr), 64'd5);
    chk("single_data", 64'(rf_data), 64'h8000_0000);
    chk("single_id", 64'(rf_id), 64'd2);
    chk("single_rv", 64'(retire_valid), 64'h1);
    step();
    chk("idle_rv", 64'(retire_valid), 64'h0);
    chk("hold_addr", 64'(rf_addr), 64'd5);

    // fresh reset so the round-robin starts at unit 0
    rst = 1'b0; step(); rst = 1'b1;
    for (int i = 0; i < 4; i++) issue(i, 10 + i);
    for (int u = 0; u < NU; u++) begin
      unit_id[u*IW +: IW] = IW'(u);
      unit_rd[u*XL +: XL] = 32'h100 + 32'(u);
    end
    unit_done = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_ack%0d", k), 64'(unit_ack), 64'(4'b0001 << k));
      step();
      if (k == 3) unit_done = 4'h0;
      chk($sformatf("rr_id%0d", k), 64'(rf_id), 64'(k));
      chk($sformatf("rr_addr%0d", k), 64'(rf_addr), 64'(10 + k));
    end

    // stall holds off unit 1
    issue(5, 7);
    unit_done = 4'b0010; unit_id[1*IW +: IW] = 3'd5; rf_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall_ack%0d", k), 64'(unit_ack), 64'h0);
      step();
      chk($sformatf("stall_we%0d", k), 64'(rf_we), 64'h0);
      chk($sformatf("stall_rv%0d", k), 64'(retire_valid), 64'h0);
    end
    rf_stall = 1'b0;
    #1 chk("unstall_ack", 64'(unit_ack), 64'h2);
    step();
    unit_done = 4'h0;
    chk("unstall_addr", 64'(rf_addr), 64'd7);
    chk("unstall_id", 64'(rf_id), 64'd5);

    // x0 destination retires without a write
    issue(4, 0);
    unit_done = 4'b0100; unit_id[2*IW +: IW] = 3'd4;
    #1 chk("x0_ack", 64'(unit_ack), 64'h4);
    step();
    unit_done = 4'h0;
    chk("x0_rv", 64'(retire_valid), 64'h1);
    chk("x0_we", 64'(rf_we), 64'h0);
    chk("x0_id", 64'(rf_id), 64'd4);

    // retire id 1 while reissuing it: old rd used now, new rd next time
    issue(1, 20);
    unit_done = 4'b1000; unit_id[3*IW +: IW] = 3'd1;
    issue_valid = 1'b1; issue_id = 3'd1; issue_rd_addr = 5'd21;
    #1 chk("reiss_ack", 64'(unit_ack), 64'h8);
    step();
    issue_valid = 1'b0;
    unit_done = 4'b0001; unit_id[0*IW +: IW] = 3'd1;
    chk("reiss_old", 64'(rf_addr), 64'd20);
    #1 chk("reiss_ack2", 64'(unit_ack), 64'h1);
    step();
    unit_done = 4'h0;
    chk("reiss_new", 64'(rf_addr), 64'd21);
    chk("reiss_we", 64'(rf_we), 64'h1);
    chk("no_err", 64'(wb_error), 64'h0);

    // reset asserted while a result is pending
    unit_done = 4'b0001; rst = 1'b0;
    #1 chk("midrst_ack", 64'(unit_ack), 64'h0);
    step();
    chk("midrst_rv", 64'(retire_valid), 64'h0);
    chk("midrst_data", 64'(rf_data), 64'h0);
    chk("midrst_id", 64'(rf_id), 64'h0);
    unit_done = 4'h0; rst = 1'b1;
    step();

    // retire of never-issued id 6 from unit 2
    unit_done = 4'b0100; unit_id[2*IW +: IW] = 3'd6;
    #1 chk("bad_ack", 64'(unit_ack), 64'h4);
    step();
    unit_done = 4'h0;
    chk("bad_rv", 64'(retire_valid), 64'h1);
`ifdef WB_ERROR_CHECK_EN
    chk("err_set", 64'(wb_error), 64'h1);
    step(); step();
    chk("err_sticky", 64'(wb_error), 64'h1);
    rst = 1'b0; step(); rst = 1'b1;
    chk("err_clr", 64'(wb_error), 64'h0);
`else
    chk("err_off", 64'(wb_error), 64'h0);
    step(); step();
    chk("err_off2", 64'(wb_error), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
